multdiv_ctrl: RTL



---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_watchdog.sv | 28 ++
 rtl/multdiv_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings and default constants for the mult/div issue/retire controller.
package multdiv_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_kind_t;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter that flags when the unit has been waited on for TIMEOUT cycles.
module multdiv_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Saturates at the terminal value so a stray extra enable can never wrap.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/retire controller: captures one mult/div from execute, strobes the unit once,
// stalls until ready (or watchdog expiry) and emits one registered writeback beat.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 64,
  parameter logic [4:0]  RSTATUS_REG   = multdiv_pkg::RSTATUS_REG,
  parameter logic [31:0] MULT_EXC_CODE = multdiv_pkg::MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE  = multdiv_pkg::DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_operandA,
  input  logic [31:0] ex_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  logic [1:0] state;
  op_kind_t   op_kind;
  logic [4:0] rd_q;
  logic       request;
  logic       wd_expired;

  assign request = ex_is_mult | ex_is_div;

  // Combinational in IDLE so the accepting cycle already freezes the pipeline.
  assign stall = ((state == S_IDLE) && request) || (state == S_ISSUE) || (state == S_WAIT);

  multdiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == S_ISSUE),
    .enable  ((state == S_WAIT) && !md_resultRDY),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      op_kind      <= OP_MULT;
      rd_q         <= '0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the transition that owns them raises them.
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_exception <= 1'b0;
      case (state)
        S_IDLE: begin
          if (request) begin
            state        <= S_ISSUE;
            op_kind      <= ex_is_mult ? OP_MULT : OP_DIV;
            rd_q         <= ex_rd;
            md_operandA  <= ex_operandA;
            md_operandB  <= ex_operandB;
            md_ctrl_MULT <= ex_is_mult;
            md_ctrl_DIV  <= !ex_is_mult;
          end
        end
        // Ready is deliberately ignored here; it may still be high from the previous op.
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (md_resultRDY || wd_expired) begin
            state    <= S_DONE;
            wb_valid <= 1'b1;
            if (md_resultRDY && !md_exception) begin
              wb_rd   <= rd_q;
              wb_data <= md_result;
            end else begin
              wb_rd        <= RSTATUS_REG;
              wb_data      <= (op_kind == OP_MULT) ? MULT_EXC_CODE : DIV_EXC_CODE;
              wb_exception <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
